// File: rtl/vga_sink_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_sink_pkg                                                    |
// | Purpose  : Shared types and constants for the VGA plot sink: default       |
// |            framebuffer geometry, coordinate/colour widths, the plot event  |
// |            record and the sink FSM state encoding.                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package vga_sink_pkg;

   localparam int unsigned XRES_DEFAULT = 160;
   localparam int unsigned YRES_DEFAULT = 120;
   localparam int unsigned COLOR_W      = 3;
   localparam int unsigned X_W          = 10;
   localparam int unsigned Y_W          = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_t;

   // One queued pixel write.
   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } plot_ev_t;

   // Row-major linear framebuffer index.
   function automatic int unsigned pixel_index(
      input logic [X_W-1:0] x,
      input logic [Y_W-1:0] y,
      input int unsigned    xres
   );
      return 32'(y) * xres + 32'(x);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_plot_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_plot_sink_if                                                |
// | Purpose  : Plot-event bus and readback bus of the VGA plot sink.           |
// | Ports    : master - drives VGA_X/VGA_Y/VGA_COLOR/plot and rd_req/rd_x/rd_y,|
// |                     receives rd_valid/rd_color                             |
// |            slave  - the sink side of the same signals                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface vga_plot_sink_if;
   import vga_sink_pkg::*;

   logic [X_W-1:0]     VGA_X;
   logic [Y_W-1:0]     VGA_Y;
   logic [COLOR_W-1:0] VGA_COLOR;
   logic               plot;

   logic               rd_req;
   logic [X_W-1:0]     rd_x;
   logic [Y_W-1:0]     rd_y;
   logic               rd_valid;
   logic [COLOR_W-1:0] rd_color;

   modport master (
      output VGA_X, VGA_Y, VGA_COLOR, plot,
      output rd_req, rd_x, rd_y,
      input  rd_valid, rd_color
   );

   modport slave (
      input  VGA_X, VGA_Y, VGA_COLOR, plot,
      input  rd_req, rd_x, rd_y,
      output rd_valid, rd_color
   );
endinterface
`default_nettype wire

// File: rtl/plot_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : plot_fifo                                                       |
// | Purpose  : Synchronous show-ahead FIFO buffering plot events. dout always  |
// |            presents the head entry while empty is low.                     |
// | Ports    : clk, rst_n (async active-low), push/din, pop/dout, full, empty  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module plot_fifo #(
   parameter int unsigned DEPTH = 8,   // power of two, >= 2
   parameter int unsigned WIDTH = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;

   logic w_push;
   logic w_pop;

   // A push on a full FIFO is refused even when a pop happens in the same
   // cycle; full is decided from the registered count only.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   assign full  = (r_count == (c_aw+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign dout  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end
endmodule
`default_nettype wire

// File: rtl/vga_plot_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_plot_sink                                                   |
// | Purpose  : Accepts pixel plot events into a FIFO, drains them into an      |
// |            XRES x YRES colour framebuffer, supports a full-screen clear    |
// |            sweep and an independent one-cycle-latency readback port.       |
// | Ports    : CLOCK_50, Resetn (async active-low)                             |
// |            bus         - plot bus and readback bus (slave modport)         |
// |            clear       - clear-screen request, clear_color fill colour     |
// |            busy        - clear running or events pending                   |
// |            overflow    - sticky event-lost flag                            |
// |            plot_count  - framebuffer pixel writes (wrapping)               |
// |            drop_count  - out-of-range events (saturating)                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_plot_sink
   import vga_sink_pkg::*;
#(
   parameter int unsigned XRES       = XRES_DEFAULT,
   parameter int unsigned YRES       = YRES_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                CLOCK_50,
   input  logic                Resetn,
   vga_plot_sink_if.slave      bus,
   input  logic                clear,
   input  logic [COLOR_W-1:0]  clear_color,
   output logic                busy,
   output logic                overflow,
   output logic [15:0]         plot_count,
   output logic [7:0]          drop_count
);
   localparam int unsigned c_fb_size = XRES * YRES;
   localparam int unsigned c_aw      = $clog2(c_fb_size);
   localparam int unsigned c_ev_w    = $bits(plot_ev_t);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t             r_state;
   logic [c_aw-1:0]    r_clr_addr;
   logic [COLOR_W-1:0] r_clear_color;
   logic [15:0]        r_plot_count;
   logic [7:0]         r_drop_count;
   logic               r_overflow;

   logic [COLOR_W-1:0] r_fb [c_fb_size];
   logic [COLOR_W-1:0] r_rd_data;
   logic               r_rd_valid;
   logic               r_rd_hit;

   // ---------------------------------------------------------------------
   // Push side
   // ---------------------------------------------------------------------
   logic     w_plot_in_range;
   logic     w_fifo_full;
   logic     w_fifo_empty;
   logic     w_push;
   logic     w_pop;
   plot_ev_t w_ev_in;
   plot_ev_t w_ev_out;

   assign w_plot_in_range = bus.plot
                         && (32'(bus.VGA_X) < XRES)
                         && (32'(bus.VGA_Y) < YRES);
   assign w_push  = w_plot_in_range && !w_fifo_full;
   assign w_ev_in = '{x: bus.VGA_X, y: bus.VGA_Y, color: bus.VGA_COLOR};

   // A clear request seen in DRAIN takes priority over that cycle's pop.
   assign w_pop = (r_state == DRAIN) && !w_fifo_empty && !clear;

   plot_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_ev_w)
   ) u_plot_fifo (
      .clk   (CLOCK_50),
      .rst_n (Resetn),
      .push  (w_push),
      .din   (w_ev_in),
      .pop   (w_pop),
      .dout  (w_ev_out),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   // ---------------------------------------------------------------------
   // FSM, counters and status
   // ---------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_state       <= IDLE;
         r_clr_addr    <= '0;
         r_clear_color <= '0;
         r_plot_count  <= '0;
         r_drop_count  <= '0;
         r_overflow    <= 1'b0;
      end else begin
         if (bus.plot && !w_plot_in_range && (r_drop_count != 8'hFF))
            r_drop_count <= r_drop_count + 8'd1;

         if (w_plot_in_range && w_fifo_full)
            r_overflow <= 1'b1;

         if (w_pop)
            r_plot_count <= r_plot_count + 16'd1;

         case (r_state)
            IDLE: begin
               if (clear) begin
                  r_clear_color <= clear_color;
                  r_clr_addr    <= '0;
                  r_state       <= CLEAR;
               end else if (!w_fifo_empty) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (clear) begin
                  r_clear_color <= clear_color;
                  r_clr_addr    <= '0;
                  r_state       <= CLEAR;
               end else if (w_fifo_empty) begin
                  r_state <= IDLE;
               end
            end
            CLEAR: begin
               // Further clear requests are ignored until the sweep ends.
               if (r_clr_addr == c_aw'(c_fb_size - 1)) begin
                  r_clr_addr <= '0;
                  r_state    <= w_fifo_empty ? IDLE : DRAIN;
               end else begin
                  r_clr_addr <= r_clr_addr + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy       = (r_state == CLEAR) || !w_fifo_empty;
   assign overflow   = r_overflow;
   assign plot_count = r_plot_count;
   assign drop_count = r_drop_count;

   // ---------------------------------------------------------------------
   // Framebuffer: one write port (clear sweep or drained event), one read port
   // ---------------------------------------------------------------------
   logic               w_wr_en;
   logic [c_aw-1:0]    w_wr_addr;
   logic [COLOR_W-1:0] w_wr_data;
   logic               w_rd_in_range;
   logic [c_aw-1:0]    w_rd_addr;

   assign w_wr_en   = w_pop || (r_state == CLEAR);
   assign w_wr_addr = (r_state == CLEAR)
                    ? r_clr_addr
                    : c_aw'(pixel_index(w_ev_out.x, w_ev_out.y, XRES));
   assign w_wr_data = (r_state == CLEAR) ? r_clear_color : w_ev_out.color;

   assign w_rd_in_range = (32'(bus.rd_x) < XRES) && (32'(bus.rd_y) < YRES);
   assign w_rd_addr     = w_rd_in_range
                        ? c_aw'(pixel_index(bus.rd_x, bus.rd_y, XRES))
                        : '0;

   // Contents are deliberately not reset. The read samples the array before
   // the same-edge write lands, so a colliding read returns the old colour.
   always_ff @(posedge CLOCK_50) begin
      if (w_wr_en) r_fb[w_wr_addr] <= w_wr_data;
      r_rd_data <= r_fb[w_rd_addr];
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= bus.rd_req;
         r_rd_hit   <= bus.rd_req && w_rd_in_range;
      end
   end

   // Out-of-range reads and idle cycles present colour 0.
   assign bus.rd_valid = r_rd_valid;
   assign bus.rd_color = r_rd_hit ? r_rd_data : '0;
endmodule
`default_nettype wire

// File: tb/tb_vga_plot_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_plot_sink                                                |
// | Purpose  : Directed self-checking bench for vga_plot_sink (160x120, FIFO 8)|
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_plot_sink;
   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [2:0]  clear_color;
   logic        busy;
   logic        overflow;
   logic [15:0] plot_count;
   logic [7:0]  drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   vga_plot_sink_if bus ();

   vga_plot_sink #(
      .XRES       (160),
      .YRES       (120),
      .FIFO_DEPTH (8)
   ) dut (
      .CLOCK_50    (clk),
      .Resetn      (rst_n),
      .bus         (bus),
      .clear       (clear),
      .clear_color (clear_color),
      .busy        (busy),
      .overflow    (overflow),
      .plot_count  (plot_count),
      .drop_count  (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic plot_px(input int x, input int y, input int c);
      bus.plot      = 1'b1;
      bus.VGA_X     = 10'(x);
      bus.VGA_Y     = 9'(y);
      bus.VGA_COLOR = 3'(c);
      tick();
      bus.plot      = 1'b0;
   endtask

   task automatic read_px(input int x, input int y);
      bus.rd_req = 1'b1;
      bus.rd_x   = 10'(x);
      bus.rd_y   = 9'(y);
      tick();
      bus.rd_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 30000) begin
         tick();
         n++;
      end
      check(tag, 32'(busy), 0);
   endtask

   initial begin
      int n;
      rst_n         = 1'b0;
      clear         = 1'b0;
      clear_color   = 3'd0;
      bus.plot      = 1'b0;
      bus.VGA_X     = '0;
      bus.VGA_Y     = '0;
      bus.VGA_COLOR = '0;
      bus.rd_req    = 1'b0;
      bus.rd_x      = '0;
      bus.rd_y      = '0;
      repeat (3) tick();

      check("rst_busy",     32'(busy),         0);
      check("rst_overflow", 32'(overflow),     0);
      check("rst_plot_cnt", 32'(plot_count),   0);
      check("rst_drop_cnt", 32'(drop_count),   0);
      check("rst_rd_valid", 32'(bus.rd_valid), 0);
      check("rst_rd_color", 32'(bus.rd_color), 0);
      rst_n = 1'b1;
      tick();

      // Single plot then readback
      plot_px(5, 7, 3);
      check("busy_after_plot", 32'(busy), 1);
      wait_idle("idle_first_plot");
      check("plot_cnt_1", 32'(plot_count), 1);
      check("rd_valid_early", 32'(bus.rd_valid), 0);
      read_px(5, 7);
      check("rd_valid_57", 32'(bus.rd_valid), 1);
      check("rd_color_57", 32'(bus.rd_color), 3);
      tick();
      check("rd_valid_drop", 32'(bus.rd_valid), 0);

      // Out-of-range plots
      plot_px(200, 10, 1);
      check("drop_cnt_1", 32'(drop_count), 1);
      check("busy_oob",   32'(busy),       0);
      tick();
      check("busy_oob_2", 32'(busy),       0);
      check("plot_cnt_oob", 32'(plot_count), 1);
      plot_px(10, 120, 1);
      check("drop_cnt_y_edge", 32'(drop_count), 2);

      // Last valid pixel
      plot_px(159, 119, 4);
      wait_idle("idle_corner");
      check("plot_cnt_2", 32'(plot_count), 2);
      read_px(159, 119);
      check("rd_color_corner", 32'(bus.rd_color), 4);

      // Out-of-range read
      read_px(160, 0);
      check("rd_valid_oob", 32'(bus.rd_valid), 1);
      check("rd_color_oob", 32'(bus.rd_color), 0);

      // Read colliding with the drain write of (5,7): old then new
      bus.plot = 1'b1; bus.VGA_X = 10'd5; bus.VGA_Y = 9'd7; bus.VGA_COLOR = 3'd2;
      tick();
      bus.plot = 1'b0;
      tick();
      read_px(5, 7);
      check("rbw_old", 32'(bus.rd_color), 3);
      read_px(5, 7);
      check("rbw_new", 32'(bus.rd_color), 2);
      check("plot_cnt_3", 32'(plot_count), 3);

      // Full clear to 6
      clear = 1'b1; clear_color = 3'd6;
      tick();
      clear = 1'b0;
      n = 0;
      while (busy && n < 30000) begin
         n++;
         tick();
      end
      check("clear_busy_cycles", 32'(n), 19200);
      bus.rd_req = 1'b1;
      for (int y = 0; y < 120; y++) begin
         for (int x = 0; x < 160; x++) begin
            bus.rd_x = 10'(x);
            bus.rd_y = 9'(y);
            tick();
            check("clear6_pixel", 32'(bus.rd_color), 6);
         end
      end
      bus.rd_req = 1'b0;
      check("plot_cnt_after_clear", 32'(plot_count), 3);

      // Clear to 5 with 12 plots queued during the sweep and an ignored clear
      clear = 1'b1; clear_color = 3'd5;
      tick();
      for (int i = 0; i < 12; i++) begin
         bus.plot      = 1'b1;
         bus.VGA_X     = 10'(i);
         bus.VGA_Y     = 9'd50;
         bus.VGA_COLOR = 3'((i % 7) + 1);
         clear         = (i == 3);
         clear_color   = 3'd3;
         tick();
      end
      bus.plot = 1'b0;
      clear    = 1'b0;
      check("busy_mid_clear", 32'(busy), 1);
      check("overflow_set",   32'(overflow), 1);
      wait_idle("idle_after_clear5");
      check("plot_cnt_11", 32'(plot_count), 11);
      for (int i = 0; i < 12; i++) begin
         read_px(i, 50);
         check("queued_px", 32'(bus.rd_color), (i < 8) ? ((i % 7) + 1) : 5);
      end
      read_px(100, 100);
      check("clear5_pixel", 32'(bus.rd_color), 5);

      // drop_count saturation
      bus.plot = 1'b1; bus.VGA_X = 10'd300; bus.VGA_Y = 9'd300;
      repeat (260) tick();
      bus.plot = 1'b0;
      check("drop_cnt_sat", 32'(drop_count), 255);

      // Reset in the middle of a clear to 7, at sweep address 100
      clear = 1'b1; clear_color = 3'd7;
      tick();
      clear = 1'b0;
      repeat (99) tick();
      read_px(5, 7);
      check("pre_rst_rd_valid", 32'(bus.rd_valid), 1);
      check("pre_rst_rd_color", 32'(bus.rd_color), 5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",     32'(busy),         0);
      check("mid_rst_overflow", 32'(overflow),     0);
      check("mid_rst_plot_cnt", 32'(plot_count),   0);
      check("mid_rst_drop_cnt", 32'(drop_count),   0);
      check("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
      check("mid_rst_rd_color", 32'(bus.rd_color), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", 32'(busy), 0);
      read_px(99, 0);
      check("partial_clear_99",  32'(bus.rd_color), 7);
      read_px(100, 0);
      check("partial_clear_100", 32'(bus.rd_color), 5);
      read_px(150, 0);
      check("partial_clear_150", 32'(bus.rd_color), 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire

// File: doc/vga_plot_sink.md
VGA_PLOT_SINK -- requirements
Module: vga_plot_sink

Interface
REQ-001 The block SHALL have parameter XRES, default 160, giving the framebuffer width in pixels.
REQ-002 The block SHALL have parameter YRES, default 120, giving the framebuffer height in pixels.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8 (power of two), giving the plot-event buffer depth.
REQ-004 CLOCK_50  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 Resetn  in  1  asynchronous active-low reset.
REQ-006 VGA_X  in  10  plot column.
REQ-007 VGA_Y  in  9  plot row.
REQ-008 VGA_COLOR  in  3  plot colour, 0-7.
REQ-009 plot  in  1  pixel-write strobe; each cycle high is one plot event.
REQ-010 clear  in  1  clear-screen request, sampled each cycle.
REQ-011 clear_color  in  3  fill colour, latched when a clear is accepted.
REQ-012 rd_req  in  1  readback request.
REQ-013 rd_x  in  10  readback column.
REQ-014 rd_y  in  9  readback row.
REQ-015 rd_valid  out  1  readback data valid.
REQ-016 rd_color  out  3  readback colour.
REQ-017 busy  out  1  clear in progress or events pending.
REQ-018 overflow  out  1  sticky: an event was lost because the FIFO was full.
REQ-019 plot_count  out  16  pixels written to the framebuffer.
REQ-020 drop_count  out  8  out-of-range events.

Function
REQ-021 An event with plot=1, VGA_X<XRES and VGA_Y<YRES SHALL be pushed into the FIFO as {x,y,color} in the same cycle, unless the FIFO is full.
REQ-022 An out-of-range event SHALL NOT be pushed and SHALL increment drop_count, saturating at 255.
REQ-023 An in-range event arriving while the FIFO is full SHALL be discarded and SHALL set overflow, which stays 1 until reset.
REQ-024 A simultaneous push and pop on a full FIFO SHALL count as full, so the event is discarded.
REQ-025 The FSM SHALL have states IDLE, DRAIN and CLEAR.
REQ-026 IDLE->DRAIN SHALL occur when the FIFO is non-empty.
REQ-027 DRAIN SHALL pop one entry per cycle and write fb[y*XRES+x]=color in that cycle.
REQ-028 DRAIN->IDLE SHALL occur when the FIFO empties.
REQ-029 plot_count SHALL increment by 1 per framebuffer pixel write and wrap at 65535->0.
REQ-030 clear=1 in IDLE or DRAIN SHALL latch clear_color, enter CLEAR next cycle, and suspend FIFO pops; the push side SHALL keep accepting events.
REQ-031 CLEAR SHALL write the latched colour to addresses 0..XRES*YRES-1, one per cycle, without changing plot_count.
REQ-032 After the last address, CLEAR SHALL go to DRAIN if the FIFO is non-empty, else to IDLE.
REQ-033 clear asserted while in CLEAR SHALL be ignored.
REQ-034 busy SHALL equal (state==CLEAR) OR (FIFO non-empty).
REQ-035 rd_req at cycle t SHALL give rd_valid=1 with rd_color=fb[rd_y*XRES+rd_x] at t+1; rd_valid SHALL be 0 in every cycle not preceded by rd_req.
REQ-036 A read of an out-of-range address SHALL return rd_color=0 with rd_valid=1.
REQ-037 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-038 The read port SHALL be independent of the FSM state.

Reset
REQ-039 Resetn=0 SHALL immediately force: state IDLE, FIFO empty, rd_valid=0, rd_color=0, busy=0, overflow=0, plot_count=0, drop_count=0, clear address 0.
REQ-040 Framebuffer contents SHALL NOT be reset.
REQ-041 Reset asserted mid-clear SHALL abort the sweep and leave partially cleared contents.

Structure
REQ-042 Package vga_sink_pkg SHALL hold: the default XRES/YRES, COLOR_W=3, X_W=10, Y_W=9, and the FSM state enum.
REQ-043 The FIFO SHALL be the sub-module plot_fifo (synchronous, full/empty flags, same clock and reset).
REQ-044 The framebuffer SHALL be a simple dual-port RAM inferred inside vga_plot_sink.

Verification
REQ-045 Plot (5,7,color 3) one cycle, then rd_req at (5,7) after busy=0 -> rd_color=3, rd_valid one cycle later, plot_count=1.
REQ-046 Plot X=200, Y=10 -> drop_count=1, plot_count unchanged, busy stays 0.
REQ-047 Hold plot high with valid coordinates for 12 cycles during CLEAR (FIFO_DEPTH=8) -> 8 writes after the clear ends, overflow=1.
REQ-048 Pulse clear with clear_color=6 -> busy high for 19200 cycles, every address reads 6, then plots queued during the clear are applied on top.
REQ-049 Read (5,7) in the same cycle as its write of colour 2 over colour 3 -> returns 3; the next read returns 2.
REQ-050 Assert Resetn=0 at address 100 of a clear -> all outputs at reset values immediately, address 150 keeps its old colour.
